// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin front end that shares one pipelined adder (fixed LATENCY) between
// NUM_REQ requesters. At most one operand pair is issued per cycle. A tag
// pipeline that runs in step with the adder tells which response slot gets
// each result. Each slot holds its sum and carry-out until the requester
// consumes it.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (ready is the grant)
//   req_a, req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   : per-requester response handshake
//   rsp_sum, rsp_cout     : held result per requester (same packing as req_a)
//   add_a, add_b          : registered operands driven into the external adder
//   add_sum, add_cout     : adder result, valid LATENCY edges after add_a/add_b load
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0] rsp_sum,
  output logic [NUM_REQ-1:0]       rsp_cout,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] pending_r;
  logic [LATENCY-1:0] pipe_valid_r;
  logic [PTR_W-1:0]   pipe_tag_r [LATENCY];

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [PTR_W-1:0]   cand_idx_s;
  logic [PTR_W-1:0]   ptr_next_s;
  logic               grant_any_s;
  logic               cap_s;
  logic [PTR_W-1:0]   cap_tag_s;

  // A requester with a result still in flight or unconsumed is not eligible.
  assign elig_s = req_valid & ~pending_r;

  // The last tag stage marks the edge on which add_sum belongs to that slot.
  assign cap_s     = pipe_valid_r[LATENCY-1];
  assign cap_tag_s = pipe_tag_r[LATENCY-1];

  // Grant the first eligible requester, searching from ptr_r and wrapping.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_idx_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx_s = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
      if (!grant_any_s && elig_s[cand_idx_s]) begin
        grant_any_s            = 1'b1;
        grant_idx_s            = cand_idx_s;
        grant_s[cand_idx_s]    = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // The pointer moves to the index just past the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_next_s = ptr_r;
    if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // Gate the grant with reset so the handshake is closed while reset is held.
  assign req_ready = reset ? '0 : grant_s;

  // Issue register: pointer and adder operands advance only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
      add_a <= '0;
      add_b <= '0;
    end else if (grant_any_s) begin
      ptr_r <= ptr_next_s;
      add_a <= req_a[grant_idx_s*WIDTH +: WIDTH];
      add_b <= req_b[grant_idx_s*WIDTH +: WIDTH];
    end
  end

  // Pending flag per requester: set on issue, cleared when the response is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_s[i]) begin
          pending_r[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  // Tag pipeline that shifts every edge in step with the adder and never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_r <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_tag_r[k] <= '0;
      end
    end else begin
      pipe_valid_r[0] <= grant_any_s;
      pipe_tag_r[0]   <= grant_idx_s;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid_r[k] <= pipe_valid_r[k-1];
        pipe_tag_r[k]   <= pipe_tag_r[k-1];
      end
    end
  end

  // Response slots: load from the adder when the tag arrives, hold until consumed.
  // A slot cannot be loaded while it is occupied because pending_r blocks re-issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_s && (cap_tag_s == PTR_W'(i))) begin
          rsp_valid[i]                  <= 1'b1;
          rsp_sum[i*WIDTH +: WIDTH]     <= add_sum;
          rsp_cout[i]                   <= add_cout;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
